score_engine: RTL and testbench
===============================

SCORE_ENGINE -- requirements
Module: score_engine

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- TIMER_W, 11, elapsed-time width (seconds)
- SCORE_W, 7, score width
- MAX_SCORE, 100, full score
- GRACE, 60, time at or below which full score is awarded
- LIMIT_EASY, 180, zero-score time, difficulty 0
- LIMIT_MED, 120, zero-score time, difficulty 1
- LIMIT_HARD, 90, zero-score time, difficulty 2 and 3
- ERR_W, 4, error-count width
- ERR_PENALTY, 5, points deducted per error
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge
- reset_n, in, 1, asynchronous active-low reset
- start, in, 1, request a score computation
- timer, in, TIMER_W, elapsed time, sampled with start
- difficulty, in, 2, limit select, sampled with start
- errors, in, ERR_W, wrong entries, sampled with start
- clear_best, in, 1, synchronous clear of best_score
- busy, out, 1, computation in progress
- done, out, 1, one-cycle result-valid pulse
- score, out, SCORE_W, last computed score, held
- best_score, out, SCORE_W, highest score since reset/clear
- new_record, out, 1, one-cycle pulse with done when score > previous best

Function
REQ-003 FSM SHALL have states IDLE, DIVIDE, FINISH.
REQ-004 In IDLE, start=1 SHALL capture timer, difficulty, errors and enter DIVIDE at the same edge; start in any other state SHALL be ignored.
REQ-005 Numerator SHALL be (timer - GRACE) * MAX_SCORE in NUM_W = TIMER_W + SCORE_W bits; denominator SHALL be LIMIT_x - GRACE for the captured difficulty.
REQ-006 DIVIDE SHALL run a restoring divider, one quotient bit per cycle, exactly NUM_W cycles, then enter FINISH.
REQ-007 DIVIDE SHALL run for NUM_W cycles regardless of operands, so latency is fixed.
REQ-008 FINISH SHALL form the base score: MAX_SCORE if timer <= GRACE; 0 if timer >= LIMIT_x; otherwise MAX_SCORE minus the quotient.
REQ-009 The final score SHALL be the base score minus errors * ERR_PENALTY, floored at 0; the subtraction SHALL use a width wide enough that it never wraps.
REQ-010 At the FINISH exit edge the block SHALL update score, pulse done for one cycle and return to IDLE.
REQ-011 Latency: done SHALL be high in the cycle after edge NUM_W+1, counted from the start-capture edge as edge 0 (19 edges at defaults).
REQ-012 busy SHALL be high in DIVIDE and FINISH and low in IDLE, including the done cycle; start during the done cycle SHALL be accepted.
REQ-013 On the done edge, if the final score > best_score, best_score SHALL take the final score and new_record SHALL pulse; equal scores SHALL NOT pulse.
REQ-014 clear_best SHALL zero best_score at the next edge in any state; if it coincides with the done edge, clear SHALL win and new_record SHALL still follow REQ-013 against the pre-clear best.
REQ-015 score SHALL hold its value between computations; timer, difficulty and errors SHALL be ignored outside the capture edge.

Reset
REQ-016 reset_n=0 SHALL asynchronously force IDLE, busy=0, done=0, new_record=0, score=0, best_score=0, and zero the divider registers.
REQ-017 Reset asserted mid-DIVIDE SHALL abort the computation with no done pulse; after release the block SHALL accept a new start.

Structure
REQ-018 A shared game package SHALL hold the FSM state typedef and the difficulty encodings (EASY=0, MED=1, HARD=2).
REQ-019 The divider SHALL be a sub-module named seq_divider with start/done handshake and width parameters; score_engine SHALL own the FSM, penalty, saturation and best-score logic.
REQ-020 The design SHALL contain no combinational divide or modulo operator.

Verification
REQ-021 The bench SHALL cover the following directed scenarios, with default parameters unless stated.
- Medium, timer=90, errors=0 -> score=50, done at edge 19, new_record=1, best=50.
- Medium, timer=90, errors=3 -> score=35, no new_record (best stays 50).
- Boundaries: timer=60 -> 100; medium timer=120 -> 0; easy timer=120 -> 50; hard timer=75 -> 50.
- Floor: medium, timer=100, errors=15 -> score=0; timer=30, errors=15 -> score=25.
- Start pulsed while busy is ignored (score unchanged). A back-to-back start in the done cycle is accepted.
- reset_n low at DIVIDE cycle 5 -> no done, all outputs 0. clear_best coinciding with done -> best_score=0.

Source files
------------

// File: rtl/score_engine_pkg.sv
// Shared game definitions: score FSM states and difficulty encodings.
package score_engine_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic [1:0] DIFF_EASY = 2'd0;
  localparam logic [1:0] DIFF_MED  = 2'd1;
  localparam logic [1:0] DIFF_HARD = 2'd2;

endpackage

// File: rtl/score_engine_seq_divider.sv
// Restoring divider, one quotient bit per cycle, fixed N_W-cycle latency.
// The first step runs on the load edge; done_o pulses the cycle after the
// last step, when quotient_o is valid.
//   clk, rst_n       : clock, async active-low reset
//   start_i          : load operands and begin (first step taken this edge)
//   dividend_i       : N_W-bit dividend
//   divisor_i        : D_W-bit divisor
//   done_o           : one-cycle pulse, quotient valid
//   quotient_o       : N_W-bit quotient
module seq_divider #(
  parameter int unsigned N_W = 18,
  parameter int unsigned D_W = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [N_W-1:0] dividend_i,
  input  logic [D_W-1:0] divisor_i,
  output logic           done_o,
  output logic [N_W-1:0] quotient_o
);

  localparam int unsigned CNT_W = $clog2(N_W + 1);

  logic [D_W-1:0]   rem_q, rem_d, div_q, div_d, rem_in_c, div_in_c;
  logic [N_W-1:0]   quo_q, quo_d, quo_in_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d, done_q, done_d;
  logic [D_W:0]     shift_c;
  logic             ge_c;

  // One restoring step; on start the step works on the fresh operands
  always_comb begin
    rem_in_c = rem_q;
    quo_in_c = quo_q;
    div_in_c = div_q;
    if (start_i) begin
      rem_in_c = '0;
      quo_in_c = dividend_i;
      div_in_c = divisor_i;
    end
    shift_c = {rem_in_c, quo_in_c[N_W-1]};
    ge_c    = (shift_c >= {1'b0, div_in_c});

    rem_d  = rem_q;
    quo_d  = quo_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;

    if (start_i || run_q) begin
      rem_d = ge_c ? D_W'(shift_c - {1'b0, div_in_c}) : D_W'(shift_c);
      quo_d = {quo_in_c[N_W-2:0], ge_c};
    end

    if (start_i) begin
      div_d = divisor_i;
      cnt_d = CNT_W'(N_W - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Divider state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/score_engine.sv
// Time/difficulty/error based scoring with best-score tracking.
//   clk, reset_n       : clock, async active-low reset
//   start              : request computation (accepted in IDLE only)
//   timer, difficulty, errors : operands, sampled with start
//   clear_best         : synchronous clear of best_score
//   busy               : computation in progress (DIVIDE/FINISH)
//   done, new_record   : one-cycle result pulses
//   score, best_score  : last result (held), best since reset/clear
module score_engine
  import score_engine_pkg::*;
#(
  parameter int unsigned TIMER_W     = 11,
  parameter int unsigned SCORE_W     = 7,
  parameter int unsigned MAX_SCORE   = 100,
  parameter int unsigned GRACE       = 60,
  parameter int unsigned LIMIT_EASY  = 180,
  parameter int unsigned LIMIT_MED   = 120,
  parameter int unsigned LIMIT_HARD  = 90,
  parameter int unsigned ERR_W       = 4,
  parameter int unsigned ERR_PENALTY = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [TIMER_W-1:0] timer,
  input  logic [1:0]         difficulty,
  input  logic [ERR_W-1:0]   errors,
  input  logic               clear_best,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best_score,
  output logic               new_record
);

  localparam int unsigned NUM_W = TIMER_W + SCORE_W;
  localparam int unsigned PEN_W = ERR_W + $clog2(ERR_PENALTY + 1);
  localparam int unsigned SUB_W = ((PEN_W > SCORE_W) ? PEN_W : SCORE_W) + 1;

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         diff_q, diff_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               busy_q, busy_d, done_q, done_d, rec_q, rec_d;
  logic [SCORE_W-1:0] score_q, score_d, best_q, best_d;

  logic               div_start_c, div_done;
  logic [NUM_W-1:0]   num_c, div_quo;
  logic [TIMER_W-1:0] den_c;
  logic [SCORE_W-1:0] base_c, final_c;
  logic [SUB_W-1:0]   pen_c;

  function automatic logic [TIMER_W-1:0] limit_of(input logic [1:0] d);
    case (d)
      DIFF_EASY: return TIMER_W'(LIMIT_EASY);
      DIFF_MED:  return TIMER_W'(LIMIT_MED);
      default:   return TIMER_W'(LIMIT_HARD);
    endcase
  endfunction

  // Operands from the live inputs so the divider loads on the capture edge;
  // out-of-window timers give a meaningless quotient that FINISH overrides.
  always_comb begin
    num_c = (NUM_W'(timer) - NUM_W'(GRACE)) * NUM_W'(MAX_SCORE);
    den_c = limit_of(difficulty) - TIMER_W'(GRACE);
  end

  seq_divider #(
    .N_W(NUM_W),
    .D_W(TIMER_W)
  ) u_div (
    .clk       (clk),
    .rst_n     (reset_n),
    .start_i   (div_start_c),
    .dividend_i(num_c),
    .divisor_i (den_c),
    .done_o    (div_done),
    .quotient_o(div_quo)
  );

  // Base score and error penalty, floored at zero in a non-wrapping width
  always_comb begin
    if (timer_q <= TIMER_W'(GRACE)) begin
      base_c = SCORE_W'(MAX_SCORE);
    end else if (timer_q >= limit_of(diff_q)) begin
      base_c = '0;
    end else begin
      base_c = SCORE_W'(NUM_W'(MAX_SCORE) - div_quo);
    end
    pen_c = SUB_W'(err_q) * SUB_W'(ERR_PENALTY);
    if (pen_c >= SUB_W'(base_c)) begin
      final_c = '0;
    end else begin
      final_c = SCORE_W'(SUB_W'(base_c) - pen_c);
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    diff_d      = diff_q;
    err_d       = err_q;
    score_d     = score_q;
    best_d      = best_q;
    done_d      = 1'b0;
    rec_d       = 1'b0;
    div_start_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = DIVIDE;
          timer_d     = timer;
          diff_d      = difficulty;
          err_d       = errors;
          div_start_c = 1'b1;
        end
      end
      DIVIDE: begin
        if (div_done) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
        score_d = final_c;
        done_d  = 1'b1;
        if (final_c > best_q) begin
          best_d = final_c;
          rec_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear overrides the record update; the pulse still compares to the old best
    if (clear_best) best_d = '0;

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      diff_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rec_q   <= 1'b0;
      score_q <= '0;
      best_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      diff_q  <= diff_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rec_q   <= rec_d;
      score_q <= score_d;
      best_q  <= best_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign new_record = rec_q;
  assign score      = score_q;
  assign best_score = best_q;

endmodule

// File: tb/tb_score_engine.sv
// Self-checking bench for score_engine: directed table, corner sequences,
// and randomized runs against an arithmetic reference model.
module tb_score_engine;
  import score_engine_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        clear_best = 1'b0;
  logic [10:0] timer = '0;
  logic [1:0]  difficulty = '0;
  logic [3:0]  errors = '0;
  logic        busy, done, new_record;
  logic [6:0]  score, best_score;

  int checks = 0;
  int failures = 0;
  int best_m = 0;

  always #5 clk = ~clk;

  score_engine dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .timer     (timer),
    .difficulty(difficulty),
    .errors    (errors),
    .clear_best(clear_best),
    .busy      (busy),
    .done      (done),
    .score     (score),
    .best_score(best_score),
    .new_record(new_record)
  );

  typedef struct {
    logic [1:0] d;
    int         t;
    int         e;
    int         s;
    int         rec;
    int         best;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Score from the rules: grace, linear falloff to the limit, error penalty
  function automatic int model_score(input int d, input int t, input int e);
    int lim, base, s;
    lim = (d == 0) ? 180 : (d == 1) ? 120 : 90;
    if (t <= 60) base = 100;
    else if (t >= lim) base = 0;
    else base = 100 - ((t - 60) * 100) / (lim - 60);
    s = base - 5 * e;
    if (s < 0) s = 0;
    return s;
  endfunction

  // One computation; pk/cl = cycle index after which to poke start / clear_best
  task automatic run_one(input logic [1:0] d, input int t, input int e,
                         input int es, input int er, input int eb,
                         input int pk, input int cl);
    int lat;
    @(negedge clk);
    start = 1'b1; difficulty = d; timer = 11'(t); errors = 4'(e);
    @(posedge clk); #1;
    start = 1'b0;
    timer = 11'($urandom); difficulty = 2'($urandom); errors = 4'($urandom);
    check("busy_after_start", int'(busy), 1);
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == pk) begin
        start = 1'b1; timer = 11'd60; difficulty = DIFF_EASY; errors = 4'd0;
      end
      if (lat == cl) clear_best = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      clear_best = 1'b0;
      lat++;
    end
    check("latency", lat, 19);
    check("score", int'(score), es);
    check("new_record", int'(new_record), er);
    check("best_score", int'(best_score), eb);
    check("busy_in_done_cycle", int'(busy), 0);
  endtask

  task automatic run_model(input logic [1:0] d, input int t, input int e, input int cl);
    int s, rec, nb;
    s   = model_score(int'(d), t, e);
    rec = (s > best_m) ? 1 : 0;
    nb  = (cl >= 0) ? 0 : ((rec != 0) ? s : best_m);
    run_one(d, t, e, s, rec, nb, -1, cl);
    best_m = nb;
  endtask

  initial begin
    int cnt;

    vecs[0]  = '{DIFF_MED,  90,  0, 50,  1, 50};
    vecs[1]  = '{DIFF_MED,  90,  3, 35,  0, 50};
    vecs[2]  = '{DIFF_MED,  60,  0, 100, 1, 100};
    vecs[3]  = '{DIFF_MED,  120, 0, 0,   0, 100};
    vecs[4]  = '{DIFF_EASY, 120, 0, 50,  0, 100};
    vecs[5]  = '{DIFF_HARD, 75,  0, 50,  0, 100};
    vecs[6]  = '{DIFF_MED,  100, 15, 0,  0, 100};
    vecs[7]  = '{DIFF_EASY, 30,  15, 25, 0, 100};
    vecs[8]  = '{2'd3,      80,  0, 34,  0, 100};
    vecs[9]  = '{DIFF_MED,  61,  0, 99,  0, 100};
    vecs[10] = '{DIFF_EASY, 10,  0, 100, 0, 100};

    // Reset state
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_score", int'(score), 0);
    check("rst_best", int'(best_score), 0);
    check("rst_new_record", int'(new_record), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed table, issued back-to-back in each done cycle
    for (int i = 0; i < 11; i++) begin
      run_one(vecs[i].d, vecs[i].t, vecs[i].e, vecs[i].s, vecs[i].rec, vecs[i].best, -1, -1);
    end
    best_m = 100;

    // Start while busy must be ignored
    run_one(DIFF_MED, 90, 0, 50, 0, 100, 3, -1);
    cnt = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    check("no_extra_done", cnt, 0);
    check("score_held", int'(score), 50);

    // clear_best on the done edge: clear wins, pulse uses the old best
    run_one(DIFF_EASY, 60, 0, 100, 0, 0, -1, 18);
    run_one(DIFF_MED, 90, 0, 50, 1, 0, -1, 18);
    best_m = 0;

    // Randomized runs against the model
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(1, 0) == 1) repeat (2) @(posedge clk);
      run_model(2'($urandom), int'($urandom_range(250, 0)), int'($urandom_range(15, 0)), -1);
    end

    // Reset in the middle of DIVIDE aborts without a done pulse
    @(negedge clk);
    start = 1'b1; difficulty = DIFF_MED; timer = 11'd90; errors = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_score", int'(score), 0);
    check("abort_best", int'(best_score), 0);
    check("abort_new_record", int'(new_record), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    check("abort_no_done", cnt, 0);
    best_m = 0;
    run_model(DIFF_MED, 90, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
